// File: rtl/mem_exception_if.sv
// rtl/mem_exception_if.sv - pipeline-side bus of the memory-access exception unit
interface mem_exception_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    logic              i_valid;
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_address;
    logic [ADDR_W-1:0] i_pc;
    logic              i_exc_enable;
    logic              i_ack;
    logic [1:0]        o_changeEPC;
    logic [ADDR_W-1:0] o_epc;
    logic [ADDR_W-1:0] o_bad_addr;
    logic              o_flush;
    logic              o_redirect;
    logic              o_busy;
    logic              o_double;
    logic [CNT_W-1:0]  o_exc_count;

    modport master (
        output i_valid, i_mem_read, i_mem_write, i_address, i_pc, i_exc_enable, i_ack,
        input  o_changeEPC, o_epc, o_bad_addr, o_flush, o_redirect, o_busy, o_double,
               o_exc_count
    );

    modport slave (
        input  i_valid, i_mem_read, i_mem_write, i_address, i_pc, i_exc_enable, i_ack,
        output o_changeEPC, o_epc, o_bad_addr, o_flush, o_redirect, o_busy, o_double,
               o_exc_count
    );
endinterface

// File: rtl/mem_exception_unit.sv
// rtl/mem_exception_unit.sv - classifies memory-stage addresses and sequences flush/redirect/handler
module mem_exception_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] MEM_LIMIT    = 32'h00100000,
    parameter logic [ADDR_W-1:0] PROT_LO      = 32'h0000FF00,
    parameter logic [ADDR_W-1:0] PROT_HI      = 32'h00010000,
    parameter int                FLUSH_CYCLES = 3,
    parameter int                CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_exception_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HANDLER  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;
    logic              double_q, double_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic out_range, prot, fault;

    assign out_range = bus.i_address >= MEM_LIMIT;
    assign prot      = (bus.i_address > PROT_LO) && (bus.i_address < PROT_HI);
    assign fault     = bus.i_valid && (bus.i_mem_read || bus.i_mem_write) && (out_range || prot);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        bad_addr_d  = bad_addr_q;
        double_d    = double_q;
        count_d     = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fault && bus.i_exc_enable) begin
                    // out_range wins when an address is both beyond the limit and protected
                    cause_d     = out_range ? 2'b01 : 2'b10;
                    epc_d       = bus.i_pc;
                    bad_addr_d  = bus.i_address;
                    flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                    state_d     = ST_FLUSH;
                    if (!(&count_q)) count_d = count_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) state_d = ST_REDIRECT;
                else                     flush_cnt_d = flush_cnt_q - 4'd1;
            end
            ST_REDIRECT: state_d = ST_HANDLER;
            ST_HANDLER: begin
                // the enable mask does not hide a fault raised inside the handler
                if (fault) double_d = 1'b1;
                if (bus.i_ack) begin
                    state_d = ST_IDLE;
                    cause_d = 2'b00;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 4'd0;
            cause_q     <= 2'b00;
            epc_q       <= '0;
            bad_addr_q  <= '0;
            double_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            bad_addr_q  <= bad_addr_d;
            double_q    <= double_d;
            count_q     <= count_d;
        end
    end

    assign bus.o_changeEPC = cause_q;
    assign bus.o_epc       = epc_q;
    assign bus.o_bad_addr  = bad_addr_q;
    assign bus.o_flush     = (state_q == ST_FLUSH);
    assign bus.o_redirect  = (state_q == ST_REDIRECT);
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_double    = double_q;
    assign bus.o_exc_count = count_q;
endmodule

// File: tb/tb_mem_exception_unit.sv
// tb/tb_mem_exception_unit.sv - directed vector bench for mem_exception_unit
module tb_mem_exception_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_exception_if #(.ADDR_W(32), .CNT_W(8)) bus_a ();
    mem_exception_if #(.ADDR_W(32), .CNT_W(2)) bus_b ();

    mem_exception_unit #(.CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mem_exception_unit #(.CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int checks   = 0;
    int failures = 0;
    int cnt_exp  = 0;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] p, input logic en, input logic ack);
        bus_a.i_valid = v;  bus_a.i_mem_read = r; bus_a.i_mem_write = w;
        bus_a.i_address = a; bus_a.i_pc = p; bus_a.i_exc_enable = en; bus_a.i_ack = ack;
        bus_b.i_valid = v;  bus_b.i_mem_read = r; bus_b.i_mem_write = w;
        bus_b.i_address = a; bus_b.i_pc = p; bus_b.i_exc_enable = en; bus_b.i_ack = ack;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, " cause"},  32'(bus_a.o_changeEPC), 32'd0);
        chk({tag, " epc"},    bus_a.o_epc, 32'd0);
        chk({tag, " bad"},    bus_a.o_bad_addr, 32'd0);
        chk({tag, " flush"},  32'(bus_a.o_flush), 32'd0);
        chk({tag, " redir"},  32'(bus_a.o_redirect), 32'd0);
        chk({tag, " busy"},   32'(bus_a.o_busy), 32'd0);
        chk({tag, " double"}, 32'(bus_a.o_double), 32'd0);
        chk({tag, " count"},  32'(bus_a.o_exc_count), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00100000, 32'h0000_1000, 2'b01};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000FF00, 32'h0000_1004, 2'b00};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000FF01, 32'h0000_1008, 2'b10};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000FFFF, 32'h0000_100C, 2'b10};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h00010000, 32'h0000_1010, 2'b00};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0000_1014, 2'b01};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h00200000, 32'h0000_1018, 2'b00};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h000FFFFF, 32'h0000_101C, 2'b00};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h0000_1020, 2'b01};

        idle_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_all_zero("reset");

        // basic fault: flush N+1..N+3, redirect N+4, handler from N+5
        drive(1'b1, 1'b1, 1'b0, 32'h00100000, 32'h40, 1'b1, 1'b0);
        tick();
        idle_in();
        chk("t1 cause", 32'(bus_a.o_changeEPC), 32'd1);
        chk("t1 epc", bus_a.o_epc, 32'h40);
        chk("t1 bad", bus_a.o_bad_addr, 32'h00100000);
        chk("t1 count", 32'(bus_a.o_exc_count), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("t1 flush c%0d", c), 32'(bus_a.o_flush), 32'((c >= 1) && (c <= 3)));
            chk($sformatf("t1 redir c%0d", c), 32'(bus_a.o_redirect), 32'(c == 4));
            chk($sformatf("t1 busy c%0d", c), 32'(bus_a.o_busy), 32'd1);
            if (c < 5) tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        idle_in();
        chk("t1 ack busy", 32'(bus_a.o_busy), 32'd0);
        chk("t1 ack cause", 32'(bus_a.o_changeEPC), 32'd0);
        chk("t1 ack epc hold", bus_a.o_epc, 32'h40);

        // masked fault
        drive(1'b1, 1'b1, 1'b0, 32'h00200000, 32'h80, 1'b0, 1'b0);
        tick();
        idle_in();
        chk("mask busy", 32'(bus_a.o_busy), 32'd0);
        chk("mask count", 32'(bus_a.o_exc_count), 32'd1);
        chk("mask double", 32'(bus_a.o_double), 32'd0);

        // ack while idle
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        idle_in();
        chk("idle ack busy", 32'(bus_a.o_busy), 32'd0);
        chk("idle ack epc", bus_a.o_epc, 32'h40);

        // fault during flush ignored, fault in handler sets sticky double
        drive(1'b1, 1'b1, 1'b0, 32'h00100000, 32'h100, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0000FF80, 32'h200, 1'b1, 1'b0);
        tick();
        idle_in();
        chk("dbl flush double", 32'(bus_a.o_double), 32'd0);
        chk("dbl flush epc", bus_a.o_epc, 32'h100);
        tick(); tick(); tick();
        chk("dbl in handler", 32'(bus_a.o_busy & ~bus_a.o_flush & ~bus_a.o_redirect), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h00300000, 32'h300, 1'b0, 1'b0);
        tick();
        idle_in();
        chk("dbl double", 32'(bus_a.o_double), 32'd1);
        chk("dbl epc", bus_a.o_epc, 32'h100);
        chk("dbl bad", bus_a.o_bad_addr, 32'h00100000);
        chk("dbl count", 32'(bus_a.o_exc_count), 32'd2);
        chk("dbl busy", 32'(bus_a.o_busy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        // back-to-back fault in the IDLE cycle right after ack
        drive(1'b1, 1'b0, 1'b1, 32'h0000FF10, 32'h400, 1'b1, 1'b0);
        chk("dbl ack busy", 32'(bus_a.o_busy), 32'd0);
        chk("dbl ack double", 32'(bus_a.o_double), 32'd1);
        chk("dbl ack cause", 32'(bus_a.o_changeEPC), 32'd0);
        tick();
        idle_in();
        chk("b2b busy", 32'(bus_a.o_busy), 32'd1);
        chk("b2b cause", 32'(bus_a.o_changeEPC), 32'd2);
        chk("b2b epc", bus_a.o_epc, 32'h400);
        chk("b2b count", 32'(bus_a.o_exc_count), 32'd3);

        // reset at N+2, during flush
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h00100000, 32'h500, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        idle_in();
        check_all_zero("midrst");
        chk("midrst b count", 32'(bus_b.o_exc_count), 32'd0);

        // classification table; instance b checks 2-bit saturation
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].pc, 1'b1, 1'b0);
            tick();
            idle_in();
            if (vecs[i].exp_cause != 2'b00) cnt_exp++;
            chk($sformatf("vec%0d cause", i), 32'(bus_a.o_changeEPC), 32'(vecs[i].exp_cause));
            chk($sformatf("vec%0d busy", i), 32'(bus_a.o_busy), 32'(vecs[i].exp_cause != 2'b00));
            chk($sformatf("vec%0d count", i), 32'(bus_a.o_exc_count), 32'(cnt_exp));
            chk($sformatf("vec%0d cnt2", i), 32'(bus_b.o_exc_count), 32'(sat3(cnt_exp)));
            if (vecs[i].exp_cause != 2'b00) begin
                chk($sformatf("vec%0d epc", i), bus_a.o_epc, vecs[i].pc);
                chk($sformatf("vec%0d bad", i), bus_a.o_bad_addr, vecs[i].addr);
                tick(); tick(); tick(); tick();
                drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
                tick();
                idle_in();
                chk($sformatf("vec%0d ack busy", i), 32'(bus_a.o_busy), 32'd0);
            end
        end
        chk("final double", 32'(bus_a.o_double), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not end, expected finish before 200000");
        $fatal(1);
    end
endmodule
